tok_sched: RTL

Two-requester character-stream scheduler with an embedded identifier scanner. Two byte producers, A and B, share one identifier-recognition datapath. The block grants the datapath one whole token at a time, with round-robin order at token boundaries. It forwards accepted characters and reports each finished token: source, validity and length. It also keeps per-source counts of valid identifiers.

---
 rtl/tok_pkg.sv | 33 +++
 rtl/ident_scan.sv | 64 ++++++
 rtl/tok_sched.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/tok_pkg.sv
// tok_pkg: shared constants and types for the tok_sched character scheduler.
//   - character class bounds (ASCII)
//   - arbiter state encoding
//   - source encoding
//   - character class helpers used by the scanner
package tok_pkg;

    localparam logic [7:0] CH_A_UP = 8'd65;   // 'A'
    localparam logic [7:0] CH_Z_UP = 8'd90;   // 'Z'
    localparam logic [7:0] CH_A_LO = 8'd97;   // 'a'
    localparam logic [7:0] CH_Z_LO = 8'd122;  // 'z'
    localparam logic [7:0] CH_0    = 8'd48;   // '0'
    localparam logic [7:0] CH_9    = 8'd57;   // '9'

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    function automatic logic is_letter(input logic [7:0] c);
        return ((c >= CH_A_UP) && (c <= CH_Z_UP)) ||
               ((c >= CH_A_LO) && (c <= CH_Z_LO));
    endfunction

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CH_0) && (c <= CH_9);
    endfunction

endpackage

// File: rtl/ident_scan.sv
// ident_scan: per-token identifier scanner.
//   clk, reset : clock, asynchronous active-high reset
//   char       : character being transferred this cycle
//   fire       : a transfer occurs this cycle
//   first      : the transfer (if alnum) starts a new token
//   is_delim   : combinational class decode of char (not letter, not digit)
//   ok         : token so far is an identifier (started with a letter)
//   len        : alnum characters in the token so far, saturating
// The owner samples ok/len on the edge where the terminating delimiter
// transfers; the delimiter itself never touches ok/len.
module ident_scan
    import tok_pkg::*;
#(
    parameter int LEN_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       char,
    input  logic             fire,
    input  logic             first,
    output logic             is_delim,
    output logic             ok,
    output logic [LEN_W-1:0] len
);

    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    logic             letter;
    logic             digit;
    logic             ok_reg;
    logic             ok_next;
    logic [LEN_W-1:0] len_reg;
    logic [LEN_W-1:0] len_next;

    assign letter   = is_letter(char);
    assign digit    = is_digit(char);
    assign is_delim = !(letter || digit);

    always_comb begin
        ok_next  = ok_reg;
        len_next = len_reg;
        if (first) begin
            // A token's identity is decided by its first character only.
            ok_next  = letter;
            len_next = LEN_W'(1);
        end else if (len_reg != LEN_MAX) begin
            len_next = len_reg + LEN_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ok_reg  <= 1'b0;
            len_reg <= '0;
        end else if (fire && !is_delim) begin
            ok_reg  <= ok_next;
            len_reg <= len_next;
        end
    end

    assign ok  = ok_reg;
    assign len = len_reg;

endmodule

// File: rtl/tok_sched.sv
// tok_sched: two-source character scheduler sharing one identifier scanner.
//   clk, reset        : clock, asynchronous active-high reset
//   a_valid/a_char    : source A offer; a_ready completes the handshake
//   b_valid/b_char    : source B offer; b_ready completes the handshake
//   o_valid/o_char    : forwarded character, registered (1 cycle latency)
//   o_src             : source of the forwarded character (0=A, 1=B)
//   tok_done          : one-cycle pulse alongside the terminating delimiter
//   tok_ok/len/src    : result of the finished token, held until next tok_done
//   cnt_a/cnt_b       : saturating counts of valid identifiers per source
// Tokens are granted whole: once an alnum character is accepted from a
// source, that source owns the scanner until it sends a delimiter.
module tok_sched
    import tok_pkg::*;
#(
    parameter int LEN_W = 6,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             a_valid,
    input  logic [7:0]       a_char,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [7:0]       b_char,
    output logic             b_ready,
    output logic             o_valid,
    output logic [7:0]       o_char,
    output logic             o_src,
    output logic             tok_done,
    output logic             tok_ok,
    output logic [LEN_W-1:0] tok_len,
    output logic             tok_src,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    state_t           state_reg;
    state_t           state_next;
    logic             last_reg;
    logic             last_next;

    logic             grant;
    logic             grant_valid;
    logic             sel_src;
    logic [7:0]       sel_char;
    logic             fire;
    logic             first;
    logic             finish;

    logic             scan_delim;
    logic             scan_ok;
    logic [LEN_W-1:0] scan_len;

    logic             o_valid_reg;
    logic [7:0]       o_char_reg;
    logic             o_src_reg;
    logic             tok_done_reg;
    logic             tok_ok_reg;
    logic [LEN_W-1:0] tok_len_reg;
    logic             tok_src_reg;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            last_reg  <= SRC_B;   // so A wins the first tie
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
        end
    end

    // ------------------------------------------------------------------
    // Output / datapath-select logic
    // ------------------------------------------------------------------
    always_comb begin
        grant       = SRC_A;
        grant_valid = 1'b0;
        if (a_valid && b_valid) begin
            grant_valid = 1'b1;
            grant       = (last_reg == SRC_A) ? SRC_B : SRC_A;
        end else if (a_valid) begin
            grant_valid = 1'b1;
            grant       = SRC_A;
        end else if (b_valid) begin
            grant_valid = 1'b1;
            grant       = SRC_B;
        end

        a_ready = 1'b0;
        b_ready = 1'b0;
        sel_src = grant;
        case (state_reg)
            IDLE: begin
                a_ready = grant_valid && (grant == SRC_A);
                b_ready = grant_valid && (grant == SRC_B);
            end
            LOCK_A: begin
                a_ready = 1'b1;
                sel_src = SRC_A;
            end
            LOCK_B: begin
                b_ready = 1'b1;
                sel_src = SRC_B;
            end
            default: ;
        endcase
    end

    assign sel_char = (sel_src == SRC_B) ? b_char : a_char;
    assign fire     = (a_valid && a_ready) || (b_valid && b_ready);
    assign first    = (state_reg == IDLE);
    // A delimiter only terminates a token when one is open; in IDLE it is
    // forwarded on its own.
    assign finish   = fire && scan_delim && !first;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        case (state_reg)
            IDLE: begin
                if (fire) begin
                    last_next = sel_src;
                    if (!scan_delim) begin
                        state_next = (sel_src == SRC_A) ? LOCK_A : LOCK_B;
                    end
                end
            end
            LOCK_A, LOCK_B: begin
                if (finish) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Shared scanner
    // ------------------------------------------------------------------
    ident_scan #(
        .LEN_W (LEN_W)
    ) u_scan (
        .clk      (clk),
        .reset    (reset),
        .char     (sel_char),
        .fire     (fire),
        .first    (first),
        .is_delim (scan_delim),
        .ok       (scan_ok),
        .len      (scan_len)
    );

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_valid_reg  <= 1'b0;
            o_char_reg   <= '0;
            o_src_reg    <= 1'b0;
            tok_done_reg <= 1'b0;
            tok_ok_reg   <= 1'b0;
            tok_len_reg  <= '0;
            tok_src_reg  <= 1'b0;
        end else begin
            o_valid_reg  <= fire;
            tok_done_reg <= finish;
            if (fire) begin
                o_char_reg <= sel_char;
                o_src_reg  <= sel_src;
            end
            if (finish) begin
                tok_ok_reg  <= scan_ok;
                tok_len_reg <= scan_len;
                tok_src_reg <= sel_src;
            end
        end
    end

    assign o_valid  = o_valid_reg;
    assign o_char   = o_char_reg;
    assign o_src    = o_src_reg;
    assign tok_done = tok_done_reg;
    assign tok_ok   = tok_ok_reg;
    assign tok_len  = tok_len_reg;
    assign tok_src  = tok_src_reg;

    // ------------------------------------------------------------------
    // Per-source identifier counters (index 0 = A, 1 = B)
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_reg;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_reg <= '0;
            end else if (finish && scan_ok && (sel_src == 1'(gi)) &&
                         (cnt_reg != {CNT_W{1'b1}})) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    assign cnt_a = g_cnt[0].cnt_reg;
    assign cnt_b = g_cnt[1].cnt_reg;

endmodule
